// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   - MODE_* : encodings of the 2-bit display mode input
//   - SEG_*  : fixed glyphs, active-low {g,f,e,d,c,b,a}
//   - HEX_GLYPH : hex digit glyph table, index = nibble value
package seg_pkg;

    localparam logic [1:0] MODE_HEX  = 2'b00;
    localparam logic [1:0] MODE_OFF  = 2'b01;
    localparam logic [1:0] MODE_LAMP = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble -> seven-segment glyph.
// Ports:
//   nib_i  in  4  digit value
//   dec_i  in  1  decimal mode: nibbles A-F render as a dash
//   seg_o  out 7  glyph {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dec_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_GLYPH[nib_i];
        if (dec_i && (nib_i > 4'd9)) begin
            seg_o = SEG_DASH;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit common-anode seven-segment driver.
// New data is loaded into a pending register and copied to the display
// register only when the scan wraps to digit 0, so a frame never tears.
// Ports:
//   clk    in  1             system clock (rising edge)
//   rst_n  in  1             synchronous active-low reset
//   value  in  4*NUM_DIGITS  digit i = value[4i+3:4i], digit 0 = an[0]
//   dp_in  in  NUM_DIGITS    decimal point request per digit, active-high
//   load   in  1             capture value/dp_in into pending register
//   mode   in  2             00 hex, 01 off, 10 lamp test, 11 decimal
//   seg    out 7             segments {g,f,e,d,c,b,a}, active-low
//   dp     out 1             decimal point, active-low
//   an     out NUM_DIGITS    anodes, active-low, at most one low
//   frame  out 1             one-cycle pulse after the scan wraps to digit 0
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero
// digits in hex/decimal modes (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 4_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [1:0]              mode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int unsigned TICK_DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("seg_scan_driver: CLK_HZ/REFRESH_HZ must be at least 2");
    end
    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
        $error("seg_scan_driver: NUM_DIGITS must be 1..8");
    end

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    gap_q, gap_d;
    logic                    frame_q, frame_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick, wrap;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    blank_sel;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [6:0]              glyph;

    // Scan timing, pending capture and frame-aligned display transfer.
    always_comb begin
        tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
        wrap       = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = wrap ? '0 : (tick ? idx_q + 1'b1 : idx_q);
        gap_d      = tick;
        frame_d    = wrap;
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (wrap) begin
            // A load on the wrap edge bypasses pending so it is not a frame late.
            disp_val_d = load ? value : pend_val_q;
            disp_dp_d  = load ? dp_in : pend_dp_q;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic lz_zeros;

    // Walk from the top digit down; a digit is blank while everything at
    // and above it is zero. Digit 0 is never blanked.
    always_comb begin
        lz_zeros = 1'b1;
        lz_blank = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            lz_zeros = lz_zeros && (disp_val_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
            if (j != NUM_DIGITS - 1) begin
                lz_blank[NUM_DIGITS-1-j] = lz_zeros;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Select the current digit's data.
    always_comb begin
        nib_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel   = disp_val_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                blank_sel = lz_blank[i];
            end
        end
        an_sel = ~(NUM_DIGITS'(1) << idx_q);
    end

    seg_hex_decode u_decode (
        .nib_i (nib_sel),
        .dec_i (mode == MODE_DEC),
        .seg_o (glyph)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        case (mode)
            MODE_OFF: begin
            end
            MODE_LAMP: begin
                seg_d = SEG_ALL;
                dp_d  = 1'b0;
                an_d  = gap_q ? '1 : an_sel;
            end
            default: begin
                seg_d = glyph;
                dp_d  = ~dp_sel | blank_sel;
                an_d  = (gap_q || blank_sel) ? '1 : an_sel;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            // Starting with the gap flag set makes digit 0's first slot
            // after reset match every other slot (one dark cycle first).
            gap_q      <= 1'b1;
            frame_q    <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            frame_q    <= frame_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver, NUM_DIGITS=4, TICK_DIV=4 (16-cycle frames).
// Frame-relative position k: k=16 (== next k=0) is the sample with frame=1;
// digit d occupies k=4d+1 (anode gap) .. k=4d+4.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [1:0]  mode;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int total = 0;
    int bad   = 0;
    int cur_k = 0;

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .CLK_HZ     (1000),
        .REFRESH_HZ (250)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .dp_in (dp_in),
        .load  (load),
        .mode  (mode),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
        end
    endtask

    // g = {glyph3,glyph2,glyph1,glyph0}, dpn = expected dp pin per digit,
    // show = digits whose anode is driven low outside the gap cycle.
    task automatic check_span(input int kfrom, input int kto, input logic [27:0] g,
                              input logic [3:0] dpn, input logic [3:0] show);
        int d;
        int ph;
        logic [3:0] ea;
        for (int k = kfrom; k <= kto; k++) begin
            step();
            cur_k = k;
            d  = (k - 1) / 4;
            ph = (k - 1) % 4;
            ea = ((ph == 0) || !show[d]) ? 4'hF : ~(4'b0001 << d);
            chk("an",    {28'd0, an},    {28'd0, ea});
            chk("seg",   {25'd0, seg},   {25'd0, g[d*7 +: 7]});
            chk("dp",    {31'd0, dp},    {31'd0, dpn[d]});
            chk("frame", {31'd0, frame}, {31'd0, (k == 16)});
        end
    endtask

    localparam logic [27:0] G_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] G_HEX  = {7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [27:0] G_DEC  = {7'h79, 7'h24, 7'h3F, 7'h3F};
    localparam logic [27:0] G_FIVE = {7'h40, 7'h40, 7'h40, 7'h12};
    localparam logic [27:0] G_LAMP = {7'h00, 7'h00, 7'h00, 7'h00};
    localparam logic [27:0] G_OFF  = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] SHOW_FIVE = 4'b0001;
`else
    localparam logic [3:0] SHOW_FIVE = 4'b1111;
`endif

    initial begin
        rst_n = 1'b0;
        value = '0;
        dp_in = '0;
        load  = 1'b0;
        mode  = 2'b00;

        // Reset held for 3 cycles.
        step(); step(); step();
        cur_k = 0;
        chk("rst_seg",   {25'd0, seg},   32'h7F);
        chk("rst_an",    {28'd0, an},    32'hF);
        chk("rst_dp",    {31'd0, dp},    32'h1);
        chk("rst_frame", {31'd0, frame}, 32'h0);

        // First frame after release: all zeros, frame pulse on the 16th sample.
        rst_n = 1'b1;
        check_span(1, 16, G_ZERO, 4'b1111, 4'b1111);

        // Mid-frame load: current frame keeps showing old data.
        check_span(1, 4, G_ZERO, 4'b1111, 4'b1111);
        value = 16'h12AF;
        dp_in = 4'b0100;
        load  = 1'b1;
        check_span(5, 5, G_ZERO, 4'b1111, 4'b1111);
        load  = 1'b0;
        check_span(6, 16, G_ZERO, 4'b1111, 4'b1111);

        // Hex mode shows 12AF with dp on digit 2.
        check_span(1, 16, G_HEX, 4'b1011, 4'b1111);

        // Decimal mode; load 0005 exactly on the wrap edge.
        mode = 2'b11;
        check_span(1, 15, G_DEC, 4'b1011, 4'b1111);
        value = 16'h0005;
        dp_in = 4'b0000;
        load  = 1'b1;
        check_span(16, 16, G_DEC, 4'b1011, 4'b1111);
        load  = 1'b0;
        mode  = 2'b00;
        check_span(1, 16, G_FIVE, 4'b1111, SHOW_FIVE);

        // Lamp test.
        mode = 2'b10;
        check_span(1, 16, G_LAMP, 4'b0000, 4'b1111);

        // Off: anodes dark, frame still pulses every 16 cycles.
        mode = 2'b01;
        check_span(1, 16, G_OFF, 4'b1111, 4'b0000);
        check_span(1, 16, G_OFF, 4'b1111, 4'b0000);

        // Pending load, then reset while idx=2: load must be lost.
        mode = 2'b00;
        check_span(1, 2, G_FIVE, 4'b1111, SHOW_FIVE);
        value = 16'hBEEF;
        dp_in = 4'b1111;
        load  = 1'b1;
        check_span(3, 3, G_FIVE, 4'b1111, SHOW_FIVE);
        load  = 1'b0;
        value = 16'h0000;
        dp_in = 4'b0000;
        check_span(4, 9, G_FIVE, 4'b1111, SHOW_FIVE);
        rst_n = 1'b0;
        step();
        cur_k = 0;
        chk("mid_rst_seg",   {25'd0, seg},   32'h7F);
        chk("mid_rst_an",    {28'd0, an},    32'hF);
        chk("mid_rst_dp",    {31'd0, dp},    32'h1);
        chk("mid_rst_frame", {31'd0, frame}, 32'h0);
        rst_n = 1'b1;
        check_span(1, 16, G_ZERO, 4'b1111, 4'b1111);
        check_span(1, 16, G_ZERO, 4'b1111, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
